// File: rtl/ddrvfifo_burst_sched.sv
// Burst scheduler for the DDR virtual FIFO.
// Owns the circular write/read pointers in DDR word space.
// Picks the next burst (write or read) with round-robin arbitration.
// Tracks DDR fill level as SIZE/FULL/EMPTY.
module ddrvfifo_burst_sched #(
    parameter int ADDR_WIDTH  = 24,
    parameter int BURST       = 8,
    parameter int LEVEL_WIDTH = 10
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST_N,
    input  logic                   SOFT_RST,
    input  logic                   INIT_DONE,
    input  logic [LEVEL_WIDTH-1:0] WR_LEVEL,
    input  logic                   WR_BURST_DONE,
    input  logic [LEVEL_WIDTH-1:0] RD_SPACE,
    input  logic                   RD_BURST_DONE,
    output logic                   CMD_EN,
    output logic                   CMD_WRITE,
    output logic [ADDR_WIDTH-1:0]  CMD_ADDR,
    input  logic                   CMD_RDY,
    output logic [ADDR_WIDTH:0]    SIZE,
    output logic                   FULL,
    output logic                   EMPTY
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CMD} state_t;

    // Burst length at each of the widths it is combined with.
    localparam logic [LEVEL_WIDTH:0]   BURST_L = (LEVEL_WIDTH+1)'(BURST);
    localparam logic [LEVEL_WIDTH-1:0] BURST_P = LEVEL_WIDTH'(BURST);
    localparam logic [ADDR_WIDTH-1:0]  BURST_A = ADDR_WIDTH'(BURST);
    localparam logic [ADDR_WIDTH:0]    BURST_S = (ADDR_WIDTH+1)'(BURST);
    localparam logic [ADDR_WIDTH:0]    DEPTH_S = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]    FULL_TH = DEPTH_S - BURST_S;

    state_t                 state_q, state_d;
    logic                   cmdWrite_q, cmdWrite_d;
    logic [ADDR_WIDTH-1:0]  cmdAddr_q, cmdAddr_d;
    logic [ADDR_WIDTH-1:0]  wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0]  rdPtr_q, rdPtr_d;
    logic [LEVEL_WIDTH-1:0] wrPend_q, wrPend_d;
    logic [LEVEL_WIDTH-1:0] rdPend_q, rdPend_d;
    logic                   rrLastWrite_q, rrLastWrite_d;
    logic [ADDR_WIDTH:0]    size_q, size_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;

    logic wrOk, rdOk, grantWrite, launch, accept;

    // Eligibility and round-robin grant; level math is one bit wider so it never wraps.
    always_comb begin
        wrOk       = ({1'b0, WR_LEVEL} >= (BURST_L + {1'b0, wrPend_q})) && (size_q <= FULL_TH);
        rdOk       = (size_q >= BURST_S) && ({1'b0, RD_SPACE} >= (BURST_L + {1'b0, rdPend_q}));
        grantWrite = wrOk && (!rdOk || !rrLastWrite_q);
        launch     = (state_q == ST_IDLE) && INIT_DONE && (wrOk || rdOk);
        accept     = (state_q == ST_CMD) && CMD_RDY;
    end

    // FSM state register; soft reset wins over any handshake in flight.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q <= ST_INIT;
        end else if (SOFT_RST) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a pending command is held until accepted regardless of INIT_DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (INIT_DONE) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!INIT_DONE) begin
                    state_d = ST_INIT;
                end else if (wrOk || rdOk) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD:  if (CMD_RDY) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM outputs; command valid exactly while in the command state.
    always_comb begin
        CMD_EN    = (state_q == ST_CMD);
        CMD_WRITE = cmdWrite_q;
        CMD_ADDR  = cmdAddr_q;
        SIZE      = size_q;
        FULL      = full_q;
        EMPTY     = empty_q;
    end

    // Datapath next state: latch the winner, advance pointers/fill on accept, retire on DONE.
    always_comb begin
        cmdWrite_d    = cmdWrite_q;
        cmdAddr_d     = cmdAddr_q;
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        size_d        = size_q;
        rrLastWrite_d = rrLastWrite_q;
        wrPend_d      = wrPend_q;
        rdPend_d      = rdPend_q;
        if (launch) begin
            cmdWrite_d = grantWrite;
            cmdAddr_d  = grantWrite ? wrPtr_q : rdPtr_q;
        end
        if (accept) begin
            rrLastWrite_d = cmdWrite_q;
            if (cmdWrite_q) begin
                wrPtr_d  = wrPtr_q + BURST_A;
                size_d   = size_q + BURST_S;
                wrPend_d = wrPend_d + BURST_P;
            end else begin
                rdPtr_d  = rdPtr_q + BURST_A;
                size_d   = size_q - BURST_S;
                rdPend_d = rdPend_d + BURST_P;
            end
        end
        if (WR_BURST_DONE && (wrPend_q != '0)) wrPend_d = wrPend_d - BURST_P;
        if (RD_BURST_DONE && (rdPend_q != '0)) rdPend_d = rdPend_d - BURST_P;
        full_d  = (size_d > FULL_TH);
        empty_d = (size_d == '0);
    end

    // Datapath registers, cleared by either reset source.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            cmdWrite_q    <= 1'b0;
            cmdAddr_q     <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            wrPend_q      <= '0;
            rdPend_q      <= '0;
            rrLastWrite_q <= 1'b0;
            size_q        <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else if (SOFT_RST) begin
            cmdWrite_q    <= 1'b0;
            cmdAddr_q     <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            wrPend_q      <= '0;
            rdPend_q      <= '0;
            rrLastWrite_q <= 1'b0;
            size_q        <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            cmdWrite_q    <= cmdWrite_d;
            cmdAddr_q     <= cmdAddr_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            wrPend_q      <= wrPend_d;
            rdPend_q      <= rdPend_d;
            rrLastWrite_q <= rrLastWrite_d;
            size_q        <= size_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
        end
    end

endmodule

// File: tb/tb_ddrvfifo_burst_sched.sv
// Directed self-checking bench for ddrvfifo_burst_sched, using a 32-word ring.
module tb_ddrvfifo_burst_sched;

    localparam int AW = 5;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rstN;
    logic          softRst;
    logic          initDone;
    logic [LW-1:0] wrLevel;
    logic          wrBurstDone;
    logic [LW-1:0] rdSpace;
    logic          rdBurstDone;
    logic          cmdEn;
    logic          cmdWrite;
    logic [AW-1:0] cmdAddr;
    logic          cmdRdy;
    logic [AW:0]   size;
    logic          full;
    logic          empty;

    int vectors = 0;
    int miscompares = 0;

    ddrvfifo_burst_sched #(.ADDR_WIDTH(AW), .BURST(8), .LEVEL_WIDTH(LW)) dut (
        .BUS_CLK(clk), .BUS_RST_N(rstN), .SOFT_RST(softRst), .INIT_DONE(initDone),
        .WR_LEVEL(wrLevel), .WR_BURST_DONE(wrBurstDone), .RD_SPACE(rdSpace),
        .RD_BURST_DONE(rdBurstDone), .CMD_EN(cmdEn), .CMD_WRITE(cmdWrite),
        .CMD_ADDR(cmdAddr), .CMD_RDY(cmdRdy), .SIZE(size), .FULL(full), .EMPTY(empty)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n cycles, sampling 1 time unit after the rising edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected command/size sequence for the alternating phase.
    logic        altWrite [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] altAddr  [4] = '{32'd0, 32'd16, 32'd8, 32'd24};
    logic [31:0] altSize  [4] = '{32'd8, 32'd16, 32'd8, 32'd16};

    // Directed sequence.
    initial begin
        rstN = 1'b0; softRst = 1'b0; initDone = 1'b0; wrLevel = 10'd64;
        wrBurstDone = 1'b0; rdSpace = '0; rdBurstDone = 1'b0; cmdRdy = 1'b0;
        applyStimulus(2);
        checkOutput("rst_en",    32'(cmdEn),    32'd0);
        checkOutput("rst_write", 32'(cmdWrite), 32'd0);
        checkOutput("rst_addr",  32'(cmdAddr),  32'd0);
        checkOutput("rst_size",  32'(size),     32'd0);
        checkOutput("rst_full",  32'(full),     32'd0);
        checkOutput("rst_empty", 32'(empty),    32'd1);

        rstN = 1'b1;
        applyStimulus(3);
        checkOutput("noinit_en", 32'(cmdEn), 32'd0);
        initDone = 1'b1;
        applyStimulus(1);
        checkOutput("idle_en", 32'(cmdEn), 32'd0);
        applyStimulus(1);
        checkOutput("w0_en",    32'(cmdEn),    32'd1);
        checkOutput("w0_write", 32'(cmdWrite), 32'd1);
        checkOutput("w0_addr",  32'(cmdAddr),  32'd0);
        cmdRdy = 1'b1;
        applyStimulus(1);
        checkOutput("w0_acc_en",  32'(cmdEn), 32'd0);
        checkOutput("w0_size",    32'(size),  32'd8);
        checkOutput("w0_empty",   32'(empty), 32'd0);
        cmdRdy = 1'b0;

        applyStimulus(1);
        checkOutput("w1_en",   32'(cmdEn),   32'd1);
        checkOutput("w1_addr", 32'(cmdAddr), 32'd8);
        for (int i = 0; i < 5; i++) begin
            initDone = ~initDone;
            applyStimulus(1);
            checkOutput("hold_en",    32'(cmdEn),    32'd1);
            checkOutput("hold_write", 32'(cmdWrite), 32'd1);
            checkOutput("hold_addr",  32'(cmdAddr),  32'd8);
        end
        initDone = 1'b1;
        cmdRdy = 1'b1;
        applyStimulus(1);
        checkOutput("w1_acc_en", 32'(cmdEn), 32'd0);
        checkOutput("w1_size",   32'(size),  32'd16);

        rdSpace = 10'd64;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("alt_en",    32'(cmdEn),    32'd1);
            checkOutput("alt_write", 32'(cmdWrite), 32'(altWrite[i]));
            checkOutput("alt_addr",  32'(cmdAddr),  altAddr[i]);
            applyStimulus(1);
            checkOutput("alt_acc_en", 32'(cmdEn), 32'd0);
            checkOutput("alt_size",   32'(size),  altSize[i]);
        end

        cmdRdy = 1'b0;
        applyStimulus(1);
        checkOutput("pre_srst_en",   32'(cmdEn),   32'd1);
        checkOutput("pre_srst_addr", 32'(cmdAddr), 32'd16);
        softRst = 1'b1; cmdRdy = 1'b1; rdSpace = '0;
        applyStimulus(1);
        checkOutput("srst_en",    32'(cmdEn),   32'd0);
        checkOutput("srst_size",  32'(size),    32'd0);
        checkOutput("srst_empty", 32'(empty),   32'd1);
        checkOutput("srst_addr",  32'(cmdAddr), 32'd0);
        softRst = 1'b0; cmdRdy = 1'b0;
        applyStimulus(2);
        checkOutput("post_srst_en",    32'(cmdEn),    32'd1);
        checkOutput("post_srst_write", 32'(cmdWrite), 32'd1);
        checkOutput("post_srst_addr",  32'(cmdAddr),  32'd0);

        cmdRdy = 1'b1;
        applyStimulus(1);
        checkOutput("fill_size", 32'(size), 32'd8);
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1);
            checkOutput("fill_en",   32'(cmdEn),   32'd1);
            checkOutput("fill_addr", 32'(cmdAddr), 32'(8 * k));
            applyStimulus(1);
            checkOutput("fill_size", 32'(size), 32'(8 * (k + 1)));
        end
        checkOutput("full_set", 32'(full), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("no_5th_write", 32'(cmdEn), 32'd0);
        end

        rdSpace = 10'd8;
        applyStimulus(1);
        checkOutput("r0_en",    32'(cmdEn),    32'd1);
        checkOutput("r0_write", 32'(cmdWrite), 32'd0);
        checkOutput("r0_addr",  32'(cmdAddr),  32'd0);
        applyStimulus(1);
        checkOutput("r0_size", 32'(size), 32'd24);
        checkOutput("r0_full", 32'(full), 32'd0);
        applyStimulus(1);
        checkOutput("wrap_en",    32'(cmdEn),    32'd1);
        checkOutput("wrap_write", 32'(cmdWrite), 32'd1);
        checkOutput("wrap_addr",  32'(cmdAddr),  32'd0);
        applyStimulus(1);
        checkOutput("wrap_size", 32'(size), 32'd32);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("rd_withheld", 32'(cmdEn), 32'd0);
        end

        rdBurstDone = 1'b1;
        applyStimulus(1);
        rdBurstDone = 1'b0;
        checkOutput("done_edge_en", 32'(cmdEn), 32'd0);
        applyStimulus(1);
        checkOutput("r1_en",    32'(cmdEn),    32'd1);
        checkOutput("r1_write", 32'(cmdWrite), 32'd0);
        checkOutput("r1_addr",  32'(cmdAddr),  32'd8);
        applyStimulus(1);
        checkOutput("r1_size", 32'(size), 32'd24);

        rdSpace = '0; wrLevel = '0; rdBurstDone = 1'b1;
        applyStimulus(2);
        rdBurstDone = 1'b0;
        checkOutput("sat_idle_en", 32'(cmdEn), 32'd0);
        rdSpace = 10'd8;
        applyStimulus(1);
        checkOutput("sat_en",   32'(cmdEn),   32'd1);
        checkOutput("sat_addr", 32'(cmdAddr), 32'd16);
        applyStimulus(1);
        checkOutput("sat_size", 32'(size), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
